// File: rtl/axi_xbar_pkg.sv
// Shared arbitration types for the AXI crossbar building blocks.
// Provides the lock-state enum and the grant-index width helper.
// Imported by the round-robin arbiter mux, its interface and sub-modules.
package axi_xbar_pkg;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    // Grant index width: ceil(log2(n)) but never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_rr_arb_mux_if.sv
// Bundle of the arbiter mux handshake: NumIn requester channels in, one merged channel out.
// slave  : view of the arbiter (consumes valid_i/data_i/ready_i, drives the rest).
// master : view of the surrounding logic (drives valid_i/data_i/ready_i).
interface axi_rr_arb_mux_if
    import axi_xbar_pkg::*;
#(
    parameter int  NumIn = 4,
    parameter type T     = logic,
    parameter int  IdxW  = idx_width(NumIn)
) ();

    logic [NumIn-1:0] valid_i;
    logic [NumIn-1:0] ready_o;
    T                 data_i [NumIn];
    logic             valid_o;
    logic             ready_i;
    T                 data_o;
    logic [IdxW-1:0]  idx_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, idx_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, idx_o
    );

endinterface

// File: rtl/rr_lzc.sv
// Find-first set bit searching upward from a start pointer, wrapping NumIn-1 -> 0.
// Latency: combinational.
// Ports: req_i request vector, start_i search origin, idx_o first hit (start_i when empty), empty_o no request.
module rr_lzc
    import axi_xbar_pkg::*;
#(
    parameter int NumIn = 4,
    parameter int IdxW  = idx_width(NumIn)
) (
    input  logic [NumIn-1:0] req_i,
    input  logic [IdxW-1:0]  start_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             empty_o
);

    logic [IdxW-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        idx_o = start_i;
        pos   = '0;
        for (int off = NumIn - 1; off >= 0; off--) begin
            pos = IdxW'((32'(start_i) + 32'(off)) % NumIn);
            if (req_i[pos]) begin
                idx_o = pos;
            end
        end
    end

    assign empty_o = ~|req_i;

endmodule

// File: rtl/axi_rr_arb_mux.sv
// Round-robin arbiter mux: merges NumIn valid/ready channels onto one, zero latency, no payload storage.
// Latency: combinational from valid_i/data_i/ready_i and state to outputs; state moves on clk_i.
// Backpressure: a grant shown with ready_i low is locked until it handshakes or its requester drops valid.
// Ports: clk_i/rst_i (async active-high); bus.slave carries valid_i/ready_o/data_i in, valid_o/ready_i/data_o/idx_o out.
module axi_rr_arb_mux
    import axi_xbar_pkg::*;
#(
    parameter int  NumIn = 4,
    parameter type T     = logic,
    parameter int  IdxW  = idx_width(NumIn)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    axi_rr_arb_mux_if.slave     bus
);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;

    logic [IdxW-1:0] rr_idx;
    logic            rr_empty;
    logic [IdxW-1:0] gnt;
    logic            vld;
    logic            hs;

    rr_lzc #(
        .NumIn (NumIn),
        .IdxW  (IdxW)
    ) u_lzc (
        .req_i   (bus.valid_i),
        .start_i (rr_q),
        .idx_o   (rr_idx),
        .empty_o (rr_empty)
    );

    // valid_o never looks at ready_i, so no ready->valid combinational path exists.
    always_comb begin
        gnt = rr_idx;
        vld = ~rr_empty;
        if (state_q == ARB_LOCKED) begin
            gnt = lock_idx_q;
            vld = bus.valid_i[lock_idx_q];
        end
    end

    assign hs          = vld & bus.ready_i;
    assign bus.valid_o = vld;
    assign bus.idx_o   = gnt;
    assign bus.data_o  = bus.data_i[gnt];

    always_comb begin
        bus.ready_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            bus.ready_o[i] = hs & (gnt == IdxW'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;
        if (hs) begin
            rr_d = (gnt == IdxW'(NumIn - 1)) ? '0 : gnt + 1'b1;
        end
        unique case (state_q)
            ARB_UNLOCKED: begin
                if (vld && !bus.ready_i) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = gnt;
                end
            end
            ARB_LOCKED: begin
                // A dropped valid while locked is a requester protocol error; release and re-arbitrate.
                if (hs || !bus.valid_i[lock_idx_q]) begin
                    state_d = ARB_UNLOCKED;
                end
            end
            default: state_d = ARB_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_UNLOCKED;
            rr_q       <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_axi_rr_arb_mux.sv
// Bench for axi_rr_arb_mux: 4-input instance with a queue-free reference model plus directed
// literal expectations, and a 1-input instance exercised with random traffic.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_axi_rr_arb_mux;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_rr_arb_mux_if #(.NumIn(4), .T(byte_t)) bus4 ();
    axi_rr_arb_mux_if #(.NumIn(1), .T(byte_t)) bus1 ();

    axi_rr_arb_mux #(.NumIn(4), .T(byte_t)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4)
    );

    axi_rr_arb_mux #(.NumIn(1), .T(byte_t)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: rotating pointer, optional held grant.
    int m_rr     = 0;
    bit m_locked = 1'b0;
    int m_lock   = 0;

    function automatic void model_eval(input logic [3:0] v, output bit mv, output int mg);
        bit found;
        found = 1'b0;
        mg    = m_rr;
        mv    = 1'b0;
        if (m_locked) begin
            mg = m_lock;
            mv = v[m_lock];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!found && v[(m_rr + k) % 4]) begin
                    found = 1'b1;
                    mg    = (m_rr + k) % 4;
                end
            end
            mv = found;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        bit mv;
        int mg;
        bit hs;
        if (rst) begin
            m_rr     = 0;
            m_locked = 1'b0;
            m_lock   = 0;
        end else begin
            model_eval(bus4.valid_i, mv, mg);
            hs = mv && bus4.ready_i;
            if (hs) m_rr = (mg + 1) % 4;
            if (!m_locked) begin
                if (mv && !bus4.ready_i) begin
                    m_locked = 1'b1;
                    m_lock   = mg;
                end
            end else if (hs || !bus4.valid_i[m_lock]) begin
                m_locked = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        bit mv;
        int mg;
        logic [3:0] mr;
        if (mon_en) begin
            model_eval(bus4.valid_i, mv, mg);
            mr = (mv && bus4.ready_i) ? 4'(1 << mg) : 4'b0000;
            chk("mdl_valid", 32'(bus4.valid_o), 32'(mv));
            chk("mdl_idx", 32'(bus4.idx_o), 32'(mg));
            chk("mdl_ready", 32'(bus4.ready_o), 32'(mr));
            if (mv) chk("mdl_data", 32'(bus4.data_o), 32'(8'hA0 + mg));
        end
    end

    // Drive one cycle's inputs, then land mid-cycle ready for sampling.
    task automatic drive(input logic [3:0] v, input logic r);
        @(posedge clk);
        #1;
        bus4.valid_i = v;
        bus4.ready_i = r;
        #3;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bus4.data_i[i] = byte_t'(8'hA0 + i);
        bus4.valid_i   = '0;
        bus4.ready_i   = 1'b0;
        bus1.valid_i   = '0;
        bus1.ready_i   = 1'b0;
        bus1.data_i[0] = '0;
        mon_en         = 1'b1;

        // Reset state
        #3;
        chk("rst_idx", 32'(bus4.idx_o), 0);
        chk("rst_valid", 32'(bus4.valid_o), 0);
        chk("rst_ready", 32'(bus4.ready_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All requesting, always ready: strict rotation
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 1'b1);
            chk("rot_idx", 32'(bus4.idx_o), 32'(i % 4));
            chk("rot_ready", 32'(bus4.ready_o), 32'(1 << (i % 4)));
        end

        // Backpressure holds grant 2 even when index 0 appears
        drive(4'b0100, 1'b0);
        chk("bp1_idx", 32'(bus4.idx_o), 2);
        chk("bp1_data", 32'(bus4.data_o), 32'h A2);
        chk("bp1_ready", 32'(bus4.ready_o), 0);
        drive(4'b0101, 1'b0);
        chk("bp2_idx", 32'(bus4.idx_o), 2);
        chk("bp2_data", 32'(bus4.data_o), 32'h A2);
        drive(4'b0101, 1'b0);
        chk("bp3_idx", 32'(bus4.idx_o), 2);
        chk("bp3_ready", 32'(bus4.ready_o), 0);
        drive(4'b0101, 1'b1);
        chk("bp4_ready", 32'(bus4.ready_o), 32'b0100);
        drive(4'b0101, 1'b1);
        chk("bp5_idx", 32'(bus4.idx_o), 0);

        // Wrap from pointer 3 to lowest requester
        drive(4'b0100, 1'b1);
        chk("wr0_idx", 32'(bus4.idx_o), 2);
        drive(4'b0011, 1'b1);
        chk("wr1_idx", 32'(bus4.idx_o), 0);
        drive(4'b0011, 1'b1);
        chk("wr2_idx", 32'(bus4.idx_o), 1);

        // Locked requester drops valid: release, then re-arbitrate
        drive(4'b0010, 1'b0);
        chk("drop0_idx", 32'(bus4.idx_o), 1);
        drive(4'b1000, 1'b0);
        chk("drop1_idx", 32'(bus4.idx_o), 1);
        chk("drop1_valid", 32'(bus4.valid_o), 0);
        drive(4'b1000, 1'b0);
        chk("drop2_idx", 32'(bus4.idx_o), 3);
        chk("drop2_valid", 32'(bus4.valid_o), 1);
        drive(4'b1000, 1'b1);
        chk("drop3_ready", 32'(bus4.ready_o), 32'b1000);

        // Reset mid-lock abandons the held grant immediately
        drive(4'b0100, 1'b1);
        chk("rl0_idx", 32'(bus4.idx_o), 2);
        drive(4'b1010, 1'b0);
        chk("rl1_idx", 32'(bus4.idx_o), 3);
        drive(4'b1010, 1'b0);
        chk("rl2_idx", 32'(bus4.idx_o), 3);
        rst = 1'b1;
        #1;
        chk("rl_rst_idx", 32'(bus4.idx_o), 1);
        chk("rl_rst_ready", 32'(bus4.ready_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus4.valid_i = 4'b1010;
        bus4.ready_i = 1'b1;
        #3;
        chk("rl3_idx", 32'(bus4.idx_o), 1);
        chk("rl3_ready", 32'(bus4.ready_o), 32'b0010);

        // Idle: idx shows pointer, nothing valid
        drive(4'b0000, 1'b1);
        chk("idle_idx", 32'(bus4.idx_o), 2);
        chk("idle_valid", 32'(bus4.valid_o), 0);
        chk("idle_ready", 32'(bus4.ready_o), 0);

        // Single-input instance: pure pass-through
        for (int i = 0; i < 1000; i++) begin
            logic v;
            logic r;
            byte_t d;
            @(posedge clk);
            #1;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = byte_t'($urandom_range(0, 255));
            bus1.valid_i   = v;
            bus1.ready_i   = r;
            bus1.data_i[0] = d;
            #3;
            chk("n1_pass", {20'(0), bus1.valid_o, bus1.ready_o, 2'(bus1.idx_o), bus1.data_o},
                           {20'(0), v, v & r, 2'b00, d});
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_rr_arb_mux.md
AXI_RR_ARB_MUX -- requirements
Module: axi_rr_arb_mux

Interface
REQ-001 SHALL have parameter NumIn, default 4, number of requesters (legal 1..32).
REQ-002 SHALL have parameter type T, default logic, payload type per channel.
REQ-003 SHALL have parameter IdxW, default $clog2(NumIn) with a minimum of 1, width of the grant index.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port valid_i, input, NumIn, per-requester valid.
REQ-007 SHALL have port ready_o, output, NumIn, per-requester ready.
REQ-008 SHALL have port data_i, input, NumIn x T, per-requester payload.
REQ-009 SHALL have port valid_o, input direction reversed: output, 1, merged valid.
REQ-010 SHALL have port ready_i, input, 1, downstream ready.
REQ-011 SHALL have port data_o, output, T, the granted payload.
REQ-012 SHALL have port idx_o, output, IdxW, index of the granted requester.

Function
REQ-013 SHALL be zero-latency, purely combinational from the requests and state to the outputs; no payload storage.
REQ-014 SHALL assert valid_o = |valid_i when unlocked, and valid_o = valid_i[lock_idx_q] when locked.
REQ-015 SHALL, when unlocked, grant the first asserted valid_i found searching upward from rr_q, wrapping NumIn-1 -> 0.
REQ-016 SHALL drive data_o = data_i[gnt] and idx_o = gnt.
REQ-017 SHALL drive ready_o[i] = ready_i AND (i == gnt) AND valid_o; all other ready_o bits SHALL be 0.
REQ-018 SHALL define a handshake as valid_o AND ready_i.
REQ-019 SHALL have two states:
- UNLOCKED to LOCKED when valid_o=1 and ready_i=0; lock_idx_q is set to gnt.
- LOCKED to UNLOCKED on a handshake.
- LOCKED to UNLOCKED when valid_i[lock_idx_q] drops. This is a protocol violation; arbitration then proceeds fresh the next cycle.
REQ-020 SHALL keep the grant fixed to lock_idx_q while LOCKED, regardless of new requests, including higher-priority ones.
REQ-021 SHALL set rr_q to (gnt+1) mod NumIn on every handshake, and hold it otherwise.
REQ-022 SHALL, with NumIn=1, pass data straight through with idx_o=0 and rr_q constantly 0.
REQ-023 SHALL allow a handshake every cycle; back-to-back grants SHALL rotate fairly, so no requester waits more than NumIn-1 handshakes.
REQ-024 SHALL drive valid_o=0 and ready_o=0 when no valid_i is asserted; idx_o then equals rr_q and data_o is don't-care.

Reset
REQ-025 SHALL, while rst_i=1, hold rr_q=0, the state in UNLOCKED, and lock_idx_q=0, asynchronously.
REQ-026 SHALL produce combinational outputs that follow REQ-014..017 from the reset state. An in-flight locked transfer is abandoned on reset.
REQ-027 SHALL resume arbitration from index 0 on the first clock edge after rst_i deasserts.

Structure
REQ-028 SHALL take the shared state enum (ARB_UNLOCKED, ARB_LOCKED) from package axi_xbar_pkg.
REQ-029 SHALL place the find-first-from-pointer logic in one sub-module, rr_lzc: inputs are the request vector and the start pointer; outputs are the index and an empty flag.
REQ-030 SHALL be free of combinational loops from ready_i to valid_o.

Verification
REQ-031 SHALL pass this scenario: NumIn=4, valid_i=4'b1111, ready_i=1 for 8 cycles -> idx_o = 0,1,2,3,0,1,2,3, with one handshake per cycle.
REQ-032 SHALL pass this scenario: valid_i=4'b0100, ready_i=0 for 3 cycles, valid_i[0] raised in cycle 2 -> idx_o=2 throughout, data_o stable, ready_o=0; ready_i=1 in cycle 4 -> handshake on 2, then idx_o=0.
REQ-033 SHALL pass this scenario: rr_q=3, valid_i=4'b0011 -> idx_o=0; after the handshake rr_q=1, and the next grant is 1.
REQ-034 SHALL pass this scenario: locked on index 1, valid_i[1] dropped with valid_i[3]=1 -> return to UNLOCKED; the next cycle grants 3.
REQ-035 SHALL pass this scenario: rst_i asserted mid-lock with ready_i=0 -> rr_q=0 and UNLOCKED immediately, and the first grant after release is the lowest asserted index.
REQ-036 SHALL pass this scenario: NumIn=1, random valid/ready for 1000 cycles -> data_o==data_i[0], ready_o==ready_i&valid_i, idx_o=0.
